// File: rtl/imem_dmem_arbiter.sv
// Two-requestor memory arbiter: an instruction-fetch port and a load/store port
// share one memory port, with round-robin on ties and a sticky protocol-error flag.
module imem_dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_read,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_resp,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W/8-1:0] d_wmask,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_resp,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W/8-1:0] m_wmask,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_resp,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                proto_err
);

    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                last_d_r;
    logic                last_d_nxt_s;
    logic                m_read_nxt_s;
    logic                m_write_nxt_s;
    logic [ADDR_W-1:0]   m_addr_nxt_s;
    logic [DATA_W-1:0]   m_wdata_nxt_s;
    logic [MASK_W-1:0]   m_wmask_nxt_s;
    logic                proto_err_nxt_s;
    logic                want_i_s;
    logic                want_d_s;
    logic                pick_d_s;

    assign want_i_s = i_read;
    assign want_d_s = d_read | d_write;
    // D wins when alone, or on a tie when I was granted last.
    assign pick_d_s = want_d_s & (~want_i_s | ~last_d_r);

    // Next-state and next memory-port values: grant from IDLE, hold until m_resp.
    always_comb begin
        state_nxt_s     = state_r;
        last_d_nxt_s    = last_d_r;
        m_read_nxt_s    = m_read;
        m_write_nxt_s   = m_write;
        m_addr_nxt_s    = m_addr;
        m_wdata_nxt_s   = m_wdata;
        m_wmask_nxt_s   = m_wmask;
        proto_err_nxt_s = proto_err | (d_read & d_write);
        case (state_r)
            IDLE: begin
                if (pick_d_s) begin
                    state_nxt_s   = GNT_D;
                    last_d_nxt_s  = 1'b1;
                    m_addr_nxt_s  = d_addr;
                    m_wdata_nxt_s = d_wdata;
                    m_wmask_nxt_s = d_wmask;
                    // A simultaneous read+write is resolved as a write.
                    m_write_nxt_s = d_write;
                    m_read_nxt_s  = ~d_write;
                end else if (want_i_s) begin
                    state_nxt_s   = GNT_I;
                    last_d_nxt_s  = 1'b0;
                    m_addr_nxt_s  = i_addr;
                    m_read_nxt_s  = 1'b1;
                    m_write_nxt_s = 1'b0;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            GNT_I, GNT_D: begin
                if (m_resp) begin
                    state_nxt_s   = IDLE;
                    m_read_nxt_s  = 1'b0;
                    m_write_nxt_s = 1'b0;
                end else begin
                    state_nxt_s   = state_r;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                m_read_nxt_s  = 1'b0;
                m_write_nxt_s = 1'b0;
            end
        endcase
    end

    // State, arbitration history and memory-port registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            last_d_r  <= 1'b0;
            m_read    <= 1'b0;
            m_write   <= 1'b0;
            m_addr    <= {ADDR_W{1'b0}};
            m_wdata   <= {DATA_W{1'b0}};
            m_wmask   <= {MASK_W{1'b0}};
            proto_err <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            last_d_r  <= last_d_nxt_s;
            m_read    <= m_read_nxt_s;
            m_write   <= m_write_nxt_s;
            m_addr    <= m_addr_nxt_s;
            m_wdata   <= m_wdata_nxt_s;
            m_wmask   <= m_wmask_nxt_s;
            proto_err <= proto_err_nxt_s;
        end
    end

    // Route the memory completion to the granted side only; data is zero otherwise.
    always_comb begin
        i_resp  = 1'b0;
        d_resp  = 1'b0;
        i_rdata = {DATA_W{1'b0}};
        d_rdata = {DATA_W{1'b0}};
        case (state_r)
            GNT_I: begin
                if (m_resp) begin
                    i_resp  = 1'b1;
                    i_rdata = m_rdata;
                end else begin
                    i_resp  = 1'b0;
                end
            end
            GNT_D: begin
                if (m_resp) begin
                    d_resp  = 1'b1;
                    d_rdata = m_rdata;
                end else begin
                    d_resp  = 1'b0;
                end
            end
            default: begin
                i_resp = 1'b0;
                d_resp = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: directed scenarios plus randomized requestors and memory,
// all checked against a transaction-level model of who owns the memory port.
module tb_imem_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_addr;
    logic          i_resp;
    logic [DW-1:0] i_rdata;
    logic          d_read, d_write;
    logic [MW-1:0] d_wmask;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_resp;
    logic [DW-1:0] d_rdata;
    logic          m_read, m_write;
    logic [MW-1:0] m_wmask;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_resp;
    logic [DW-1:0] m_rdata;
    logic          proto_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imem_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_wmask(d_wmask), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
        .m_read(m_read), .m_write(m_write), .m_wmask(m_wmask), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_resp(m_resp), .m_rdata(m_rdata),
        .proto_err(proto_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: owner of the memory port (0 none, 1 I, 2 D) and the captured operands.
    int            own;
    logic          ex_wr, last_d, ex_perr;
    logic [AW-1:0] ex_addr;
    logic [DW-1:0] ex_wdata;
    logic [MW-1:0] ex_wmask;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            own = 0; last_d = 1'b0; ex_perr = 1'b0;
        end else begin
            if (d_read && d_write) ex_perr = 1'b1;
            if (own != 0) begin
                if (m_resp) own = 0;
            end else begin
                if (i_read && (d_read || d_write)) own = last_d ? 1 : 2;
                else if (i_read) own = 1;
                else if (d_read || d_write) own = 2;
                if (own == 1) begin
                    ex_addr = i_addr; ex_wr = 1'b0; last_d = 1'b0;
                end
                if (own == 2) begin
                    ex_addr = d_addr; ex_wdata = d_wdata; ex_wmask = d_wmask;
                    ex_wr = d_write; last_d = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("m_read", m_read, (own == 1) || (own == 2 && !ex_wr));
            check("m_write", m_write, own == 2 && ex_wr);
            if (own != 0) check("m_addr", m_addr, ex_addr);
            if (own == 2) begin
                check("m_wdata", m_wdata, ex_wdata);
                check("m_wmask", m_wmask, ex_wmask);
            end
            check("i_resp", i_resp, own == 1 && m_resp);
            check("i_rdata", i_rdata, (own == 1 && m_resp) ? m_rdata : 32'h0);
            check("d_resp", d_resp, own == 2 && m_resp);
            check("d_rdata", d_rdata, (own == 2 && m_resp) ? m_rdata : 32'h0);
            check("proto_err", proto_err, ex_perr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_read = 1'b0; i_addr = 32'h0; d_read = 1'b0; d_write = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; d_wmask = 4'h0; m_resp = 1'b0; m_rdata = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        check("rst_m_read", m_read, 1'b0);
        check("rst_m_write", m_write, 1'b0);
        check("rst_m_addr", m_addr, 32'h0);
        check("rst_m_wdata", m_wdata, 32'h0);
        check("rst_m_wmask", m_wmask, 4'h0);
        check("rst_proto_err", proto_err, 1'b0);
        check("rst_resp", {i_resp, d_resp}, 2'b00);
        rst = 1'b0;
    endtask

    bit            i_act, d_act, i_done, d_done, mem_busy;
    int            i_wait, d_wait, mem_dly, op;

    initial begin
        rst = 1'b1;
        clear_inputs();
        do_reset();

        // Lone fetch
        i_read = 1'b1; i_addr = 32'h60;
        tick(); check("fetch_m_read", m_read, 1'b1); check("fetch_m_addr", m_addr, 32'h60);
        tick();
        tick(); m_resp = 1'b1; m_rdata = 32'h13; #1;
        check("fetch_i_resp", i_resp, 1'b1); check("fetch_i_rdata", i_rdata, 32'h13);
        check("fetch_d_resp", d_resp, 1'b0);
        tick(); m_resp = 1'b0; i_read = 1'b0; check("fetch_done_m_read", m_read, 1'b0);

        // Tie after reset: D first, then I after one idle cycle
        do_reset();
        i_read = 1'b1; i_addr = 32'h100; d_read = 1'b1; d_addr = 32'h200;
        tick(); check("tie_first_addr", m_addr, 32'h200); check("tie_first_read", m_read, 1'b1);
        tick(); m_resp = 1'b1; m_rdata = 32'hAB; #1;
        check("tie_d_resp", d_resp, 1'b1); check("tie_d_rdata", d_rdata, 32'hAB);
        check("tie_i_quiet", i_resp, 1'b0);
        tick(); m_resp = 1'b0; d_read = 1'b0; check("tie_idle", m_read, 1'b0);
        tick(); check("tie_second_addr", m_addr, 32'h100); check("tie_second_read", m_read, 1'b1);
        tick(); m_resp = 1'b1; #1; check("tie_i_resp", i_resp, 1'b1);
        tick(); clear_inputs();

        // Alternation under continuous contention
        do_reset();
        i_read = 1'b1; i_addr = 32'h100; d_read = 1'b1; d_addr = 32'h200;
        for (int t = 0; t < 6; t++) begin
            tick(); check("alt_grant", m_addr, (t % 2 == 0) ? 32'h200 : 32'h100);
            tick(); m_resp = 1'b1;
            tick(); m_resp = 1'b0;
        end
        clear_inputs();

        // Store
        tick();
        d_write = 1'b1; d_addr = 32'h84; d_wdata = 32'hDEADBEEF; d_wmask = 4'b0011;
        tick();
        check("st_m_write", m_write, 1'b1); check("st_m_read", m_read, 1'b0);
        check("st_m_addr", m_addr, 32'h84); check("st_m_wdata", m_wdata, 32'hDEADBEEF);
        check("st_m_wmask", m_wmask, 4'b0011);
        tick(); check("st_hold", {m_read, m_write}, 2'b01);
        m_resp = 1'b1; #1; check("st_d_resp", d_resp, 1'b1);
        tick(); clear_inputs();

        // Request dropped before its grant edge is never granted
        d_read = 1'b1; d_addr = 32'h300;
        tick(); i_read = 1'b1; i_addr = 32'h400;
        tick(); i_read = 1'b0; m_resp = 1'b1; #1; check("drop_d_resp", d_resp, 1'b1);
        tick(); m_resp = 1'b0; d_read = 1'b0; check("drop_idle", m_read, 1'b0);
        tick(); check("drop_no_grant", m_read, 1'b0);

        // Protocol error: read+write together is a write, flag sticky until reset
        d_read = 1'b1; d_write = 1'b1; d_addr = 32'h90;
        tick();
        check("perr_m_write", m_write, 1'b1); check("perr_m_read", m_read, 1'b0);
        check("perr_flag", proto_err, 1'b1);
        tick(); m_resp = 1'b1;
        tick(); clear_inputs();
        tick(); tick(); check("perr_sticky", proto_err, 1'b1);
        do_reset();

        // Reset during GNT_D, late m_resp after release
        d_read = 1'b1; d_addr = 32'h44;
        tick(); check("rstmid_granted", m_read, 1'b1);
        rst = 1'b1; #1;
        check("rstmid_async", {m_read, m_write, d_resp}, 3'b000);
        check("rstmid_addr", m_addr, 32'h0);
        tick(); rst = 1'b0; d_read = 1'b0;
        tick(); m_resp = 1'b1; m_rdata = 32'h55; #1;
        check("late_d_resp", d_resp, 1'b0); check("late_d_rdata", d_rdata, 32'h0);
        tick(); m_resp = 1'b0; check("late_idle", {m_read, m_write}, 2'b00);

        // Randomized traffic
        i_act = 1'b0; d_act = 1'b0; i_done = 1'b0; d_done = 1'b0; mem_busy = 1'b0;
        i_wait = 0; d_wait = 0; mem_dly = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 350) begin
                rst = 1'b1;
                clear_inputs();
                i_act = 1'b0; d_act = 1'b0; i_done = 1'b0; d_done = 1'b0; mem_busy = 1'b0;
                tick();
                check("rnd_rst_idle", {m_read, m_write}, 2'b00);
                rst = 1'b0;
            end
            tick();
            m_resp = 1'b0;
            m_rdata = $urandom;
            if (mem_busy) begin
                if (mem_dly == 0) begin
                    m_resp = 1'b1; mem_busy = 1'b0;
                end else begin
                    mem_dly--;
                end
            end else if (m_read || m_write) begin
                mem_busy = 1'b1; mem_dly = $urandom_range(0, 3);
            end else if ($urandom_range(0, 9) == 0) begin
                m_resp = 1'b1;
            end
            if (i_done) begin i_act = 1'b0; i_done = 1'b0; end
            if (d_done) begin d_act = 1'b0; d_done = 1'b0; end
            if (!i_act && $urandom_range(0, 2) == 0) begin
                i_act = 1'b1; i_addr = $urandom; i_wait = 0;
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_wmask = 4'($urandom);
                d_wait = 0; op = $urandom_range(0, 19);
                d_read = (op == 0) || (op >= 10);
                d_write = (op <= 9);
            end
            i_read = i_act;
            if (!d_act) begin d_read = 1'b0; d_write = 1'b0; end
            if (i_act) i_wait++;
            if (d_act) d_wait++;
            #1;
            if (i_resp) i_done = 1'b1;
            if (d_resp) d_done = 1'b1;
            if (i_wait > 40 || d_wait > 40) begin
                n_cmp++; n_bad++;
                $display("FAIL starvation: waits i=%0d d=%0d, required <= 40", i_wait, d_wait);
                i_act = 1'b0; d_act = 1'b0; i_wait = 0; d_wait = 0;
            end
        end
        clear_inputs();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_dmem_arbiter.md
IMEM_DMEM_ARBITER -- requirements
Module: imem_dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 32: data width of all ports; mask width is DATA_W/8.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have I-side ports:
- i_read, input, 1: fetch request.
- i_addr, input, ADDR_W: fetch address.
- i_resp, output, 1: fetch complete.
- i_rdata, output, DATA_W: fetch data.
REQ-006 SHALL have D-side ports:
- d_read, input, 1: load request.
- d_write, input, 1: store request.
- d_wmask, input, DATA_W/8: byte enables.
- d_addr, input, ADDR_W: data address.
- d_wdata, input, DATA_W: store data.
- d_resp, output, 1: data access complete.
- d_rdata, output, DATA_W: load data.
REQ-007 SHALL have memory-side ports:
- m_read, output, 1: memory read.
- m_write, output, 1: memory write.
- m_wmask, output, DATA_W/8: byte enables.
- m_addr, output, ADDR_W: address.
- m_wdata, output, DATA_W: write data.
- m_resp, input, 1: memory done.
- m_rdata, input, DATA_W: read data.
REQ-008 SHALL have port proto_err, output, 1: sticky flag, set when d_read and d_write are sampled high together.

Function
REQ-009 SHALL implement FSM states IDLE, GNT_I and GNT_D.
REQ-010 Requestors hold a request and its operands stable until they see resp. The arbiter SHALL NOT depend on operands after grant.
REQ-011 In IDLE with a request pending, the FSM SHALL move at the next edge to GNT_I or GNT_D. At that same edge it SHALL register the granted operands into m_addr, m_wdata and m_wmask, and assert m_read or m_write.
REQ-012 Grant latency SHALL be 1 cycle: request visible in cycle N gives m_read/m_write high in cycle N+1.
REQ-013 Grant priority when only one side requests: that side wins.
REQ-014 Grant priority when both sides request in IDLE: round-robin. The side not granted last wins. After reset, last-granted SHALL be I, so D wins the first tie.
REQ-015 In GNT_x, m_* outputs SHALL stay constant until m_resp.
REQ-016 In the cycle m_resp=1 during GNT_I:
- i_resp=1 and i_rdata=m_rdata, combinationally.
- d_resp SHALL remain 0.
- The FSM returns to IDLE at the next edge and m_read deasserts there.
REQ-017 In the cycle m_resp=1 during GNT_D:
- d_resp=1 and d_rdata=m_rdata.
- i_resp SHALL remain 0.
- The FSM returns to IDLE at the next edge, m_read/m_write deassert there, and last-granted updates to D.
REQ-018 i_rdata and d_rdata SHALL be 0 whenever the corresponding resp is 0.
REQ-019 m_read and m_write SHALL never be high in the same cycle.
REQ-020 If d_read and d_write are both high at a D grant: the access SHALL be a write, and proto_err SHALL set at that edge.
REQ-021 m_resp received in IDLE SHALL be ignored: no resp forwarded, no state change.
REQ-022 The FSM SHALL always pass through one IDLE cycle between transactions. Minimum transaction length is 2 cycles, grant to resp.
REQ-023 A request dropped before its grant edge SHALL NOT be granted.

Reset
REQ-024 On rst asserted, asynchronously:
- FSM=IDLE and last-granted=I.
- m_read, m_write, m_addr, m_wdata, m_wmask, i_resp, d_resp, i_rdata, d_rdata and proto_err SHALL all be 0.
REQ-025 rst mid-transaction SHALL abandon the access, with no resp issued. A late m_resp after rst release SHALL be ignored per REQ-021.

Verification
REQ-026 Lone fetch: i_read=1, i_addr=0x60 in cycle 0 -> m_read=1, m_addr=0x60 in cycle 1; m_resp=1 with m_rdata=0x00000013 in cycle 3 -> i_resp=1, i_rdata=0x13 in cycle 3; m_read=0 in cycle 4.
REQ-027 Tie after reset: i_read=1 (0x100) and d_read=1 (0x200) in the same cycle -> D granted first (m_addr=0x200); after d_resp and one IDLE cycle, I is granted (m_addr=0x100).
REQ-028 Alternation: both sides request continuously for 6 transactions -> grant order D,I,D,I,D,I.
REQ-029 Store: d_write=1, d_addr=0x84, d_wdata=0xDEADBEEF, d_wmask=4'b0011 -> m_write=1 with identical operands and m_read=0 throughout; d_resp on m_resp.
REQ-030 Protocol error: d_read=1 and d_write=1 -> m_write=1, m_read=0, proto_err=1 and held until rst.
REQ-031 Reset in GNT_D, then m_resp=1 one cycle after release -> all outputs 0, d_resp never asserted, FSM IDLE.
